// File: rtl/rom_dl_ctrl_if.sv
// Loader, core and ROM write-port signals of the ROM download controller.
// The controller takes the slave view; whatever drives the loader/core side takes the master view.
interface rom_dl_ctrl_if #(
   parameter int AW = 12
);
   logic          ld_erase_en_i;
   logic          ld_wr_en_i;
   logic [31:0]   ld_wr_addr_i;
   logic [31:0]   ld_wr_data_i;
   logic          core_we_i;
   logic [31:0]   core_addr_i;
   logic [31:0]   core_wdata_i;
   logic          core_ready_o;
   logic          rom_we_o;
   logic [AW-1:0] rom_addr_o;
   logic [31:0]   rom_wdata_o;
   logic          hold_core_o;
   logic          dl_done_o;

   modport master (
      output ld_erase_en_i, ld_wr_en_i, ld_wr_addr_i, ld_wr_data_i,
      output core_we_i, core_addr_i, core_wdata_i,
      input  core_ready_o, rom_we_o, rom_addr_o, rom_wdata_o, hold_core_o, dl_done_o
   );

   modport slave (
      input  ld_erase_en_i, ld_wr_en_i, ld_wr_addr_i, ld_wr_data_i,
      input  core_we_i, core_addr_i, core_wdata_i,
      output core_ready_o, rom_we_o, rom_addr_o, rom_wdata_o, hold_core_o, dl_done_o
   );
endinterface

// File: rtl/rom_dl_ctrl.sv
// Arbitrates the instruction ROM write port between the core and the UART loader:
// erase sweep, buffered loader writes, idle timeout and core release.
module rom_dl_ctrl #(
   parameter int ROM_DEPTH    = 4096,
   parameter int AW           = 12,
   parameter int IDLE_TIMEOUT = 5000000
) (
   input logic          clk,
   input logic          rst_n,
   rom_dl_ctrl_if.slave bus
);

   localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_TIMEOUT - 1);
   localparam logic [AW-1:0] PTR_LAST = AW'(ROM_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ERASE, S_LOAD, S_RELEASE} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_vld_q, pend_vld_d;
   logic          pend_ok_q, pend_ok_d;
   logic [AW-1:0] pend_addr_q, pend_addr_d;
   logic [31:0]   pend_data_q, pend_data_d;
   logic          rom_we_q, rom_we_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [31:0]   rom_wdata_q, rom_wdata_d;
   logic          hold_core_q, hold_core_d;
   logic          dl_done_q, dl_done_d;

   // Byte-address bits [1:0] never select anything in a word-wide ROM.
   logic unused_lsbs;
   assign unused_lsbs = ^{bus.ld_wr_addr_i[1:0], bus.core_addr_i[1:0]};

   function automatic logic in_range(input logic [31:0] byte_addr);
      return (byte_addr >> (AW + 2)) == 32'd0;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      pend_vld_d  = pend_vld_q;
      pend_ok_d   = pend_ok_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      rom_we_d    = 1'b0;
      rom_addr_d  = rom_addr_q;
      rom_wdata_d = rom_wdata_q;
      dl_done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.core_we_i && in_range(bus.core_addr_i)) begin
               rom_we_d    = 1'b1;
               rom_addr_d  = bus.core_addr_i[AW+1:2];
               rom_wdata_d = bus.core_wdata_i;
            end
            if (bus.ld_erase_en_i) begin
               state_d = S_ERASE;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end

         S_ERASE: begin
            rom_we_d    = 1'b1;
            rom_addr_d  = ptr_q;
            rom_wdata_d = '0;
            ptr_d       = ptr_q + 1'b1;
            if (bus.ld_wr_en_i) begin
               pend_vld_d  = 1'b1;
               pend_ok_d   = in_range(bus.ld_wr_addr_i);
               pend_addr_d = bus.ld_wr_addr_i[AW+1:2];
               pend_data_d = bus.ld_wr_data_i;
            end
            if (ptr_q == PTR_LAST) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end
         end

         S_LOAD: begin
            // A buffered write drains first; a write arriving alongside it takes its place.
            if (pend_vld_q) begin
               if (pend_ok_q) begin
                  rom_we_d    = 1'b1;
                  rom_addr_d  = pend_addr_q;
                  rom_wdata_d = pend_data_q;
               end
               pend_vld_d  = bus.ld_wr_en_i;
               pend_ok_d   = in_range(bus.ld_wr_addr_i);
               pend_addr_d = bus.ld_wr_addr_i[AW+1:2];
               pend_data_d = bus.ld_wr_data_i;
               cnt_d       = '0;
            end else if (bus.ld_wr_en_i) begin
               if (in_range(bus.ld_wr_addr_i)) begin
                  rom_we_d    = 1'b1;
                  rom_addr_d  = bus.ld_wr_addr_i[AW+1:2];
                  rom_wdata_d = bus.ld_wr_data_i;
               end
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (bus.ld_erase_en_i) begin
               state_d = S_ERASE;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end

         S_RELEASE: begin
            dl_done_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      // Held through the RELEASE cycle itself, so it drops one cycle after dl_done.
      hold_core_d = (state_d != S_IDLE) || (state_q == S_RELEASE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         pend_vld_q  <= 1'b0;
         pend_ok_q   <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         rom_we_q    <= 1'b0;
         rom_addr_q  <= '0;
         rom_wdata_q <= '0;
         hold_core_q <= 1'b0;
         dl_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         pend_vld_q  <= pend_vld_d;
         pend_ok_q   <= pend_ok_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         rom_we_q    <= rom_we_d;
         rom_addr_q  <= rom_addr_d;
         rom_wdata_q <= rom_wdata_d;
         hold_core_q <= hold_core_d;
         dl_done_q   <= dl_done_d;
      end
   end

   assign bus.core_ready_o = (state_q == S_IDLE);
   assign bus.rom_we_o     = rom_we_q;
   assign bus.rom_addr_o   = rom_addr_q;
   assign bus.rom_wdata_o  = rom_wdata_q;
   assign bus.hold_core_o  = hold_core_q;
   assign bus.dl_done_o    = dl_done_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl (16-word ROM, 100-cycle idle timeout); ROM writes are
// checked against a queue of expected writes filled as stimulus is driven.
module tb_rom_dl_ctrl;

   localparam int DEPTH   = 16;
   localparam int AWID    = 4;
   localparam int TIMEOUT = 100;

   typedef struct packed {
      logic [AWID-1:0] addr;
      logic [31:0]     data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   wr_t  sb_q[$];
   wr_t  mon_exp;

   rom_dl_ctrl_if #(.AW(AWID)) bus ();

   rom_dl_ctrl #(
      .ROM_DEPTH    (DEPTH),
      .AW           (AWID),
      .IDLE_TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input logic [AWID-1:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      sb_q.push_back(w);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every ROM write seen mid-cycle must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.rom_we_o === 1'b1) begin
         check("sb_write_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            mon_exp = sb_q.pop_front();
            check("sb_addr", 32'(bus.rom_addr_o), 32'(mon_exp.addr));
            check("sb_data", bus.rom_wdata_o, mon_exp.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      rst_n             = 1'b0;
      bus.ld_erase_en_i = 1'b0;
      bus.ld_wr_en_i    = 1'b0;
      bus.ld_wr_addr_i  = '0;
      bus.ld_wr_data_i  = '0;
      bus.core_we_i     = 1'b0;
      bus.core_addr_i   = '0;
      bus.core_wdata_i  = '0;
      repeat (3) tick();

      check("rst_rom_we", 32'(bus.rom_we_o), 32'd0);
      check("rst_rom_addr", 32'(bus.rom_addr_o), 32'd0);
      check("rst_rom_wdata", bus.rom_wdata_o, 32'd0);
      check("rst_hold_core", 32'(bus.hold_core_o), 32'd0);
      check("rst_dl_done", 32'(bus.dl_done_o), 32'd0);
      check("rst_core_ready", 32'(bus.core_ready_o), 32'd1);
      rst_n = 1'b1;
      tick();

      // Core write in IDLE.
      bus.core_we_i    = 1'b1;
      bus.core_addr_i  = 32'h8;
      bus.core_wdata_i = 32'hDEADBEEF;
      check("idle_core_ready", 32'(bus.core_ready_o), 32'd1);
      expect_wr(4'd2, 32'hDEADBEEF);
      tick();
      bus.core_we_i = 1'b0;
      check("core_wr_we", 32'(bus.rom_we_o), 32'd1);
      check("core_wr_addr", 32'(bus.rom_addr_o), 32'd2);
      check("core_wr_ready", 32'(bus.core_ready_o), 32'd1);

      // Out-of-range core write is dropped.
      bus.core_we_i   = 1'b1;
      bus.core_addr_i = 32'h40;
      tick();
      bus.core_we_i = 1'b0;
      check("core_oor_no_we", 32'(bus.rom_we_o), 32'd0);
      check("core_oor_addr_hold", 32'(bus.rom_addr_o), 32'd2);

      // Loader write while IDLE is ignored.
      bus.ld_wr_en_i   = 1'b1;
      bus.ld_wr_addr_i = 32'h4;
      bus.ld_wr_data_i = 32'h55;
      tick();
      bus.ld_wr_en_i = 1'b0;
      check("idle_ld_ignored", 32'(bus.rom_we_o), 32'd0);

      // Erase with a simultaneous core write: core write first, then the sweep.
      bus.ld_erase_en_i = 1'b1;
      bus.core_we_i     = 1'b1;
      bus.core_addr_i   = 32'hC;
      bus.core_wdata_i  = 32'h11111111;
      expect_wr(4'd3, 32'h11111111);
      for (int i = 0; i < DEPTH; i++) expect_wr(AWID'(i), 32'h0);
      tick();
      bus.ld_erase_en_i = 1'b0;
      bus.core_we_i     = 1'b0;
      check("erase_hold_rise", 32'(bus.hold_core_o), 32'd1);
      check("erase_core_ready", 32'(bus.core_ready_o), 32'd0);
      check("erase_core_wr_first", 32'(bus.rom_addr_o), 32'd3);

      for (int i = 0; i < DEPTH; i++) begin
         if (i == 3) begin
            bus.core_we_i    = 1'b1;
            bus.core_addr_i  = 32'h4;
            bus.core_wdata_i = 32'hBAD0BAD0;
            check("sweep_core_ready", 32'(bus.core_ready_o), 32'd0);
         end
         if (i == 5) begin
            bus.ld_wr_en_i   = 1'b1;
            bus.ld_wr_addr_i = 32'h0;
            bus.ld_wr_data_i = 32'h00000013;
            expect_wr(4'd0, 32'h00000013);
         end
         tick();
         bus.core_we_i  = 1'b0;
         bus.ld_wr_en_i = 1'b0;
         check("sweep_hold", 32'(bus.hold_core_o), 32'd1);
      end

      // First LOAD cycle: last erase write visible, pending drains next, new write queues behind it.
      check("sweep_last_addr", 32'(bus.rom_addr_o), 32'd15);
      bus.ld_wr_en_i   = 1'b1;
      bus.ld_wr_addr_i = 32'h4;
      bus.ld_wr_data_i = 32'h22;
      expect_wr(4'd1, 32'h22);
      tick();
      check("pend_we", 32'(bus.rom_we_o), 32'd1);
      check("pend_addr", 32'(bus.rom_addr_o), 32'd0);
      check("pend_data", bus.rom_wdata_o, 32'h13);
      bus.ld_wr_addr_i = 32'h8;
      bus.ld_wr_data_i = 32'h33;
      expect_wr(4'd2, 32'h33);
      tick();
      bus.ld_wr_en_i = 1'b0;
      check("load_core_ready", 32'(bus.core_ready_o), 32'd0);
      repeat (50) tick();
      check("load_hold", 32'(bus.hold_core_o), 32'd1);

      // Out-of-range loader write: no ROM write, but the idle timer restarts.
      bus.ld_wr_en_i   = 1'b1;
      bus.ld_wr_addr_i = 32'h40;
      bus.ld_wr_data_i = 32'hFFFFFFFF;
      tick();
      bus.ld_wr_en_i = 1'b0;
      cnt = 1;
      while (bus.dl_done_o !== 1'b1 && cnt < 300) begin
         tick();
         cnt++;
      end
      check("dl_done_latency", 32'(cnt), 32'(TIMEOUT + 2));
      check("done_hold_still", 32'(bus.hold_core_o), 32'd1);
      tick();
      check("done_pulse_end", 32'(bus.dl_done_o), 32'd0);
      check("release_hold_fall", 32'(bus.hold_core_o), 32'd0);
      check("release_core_ready", 32'(bus.core_ready_o), 32'd1);
      check("sb_drained_load", 32'(sb_q.size()), 32'd0);

      // Reset in the middle of an erase sweep.
      bus.ld_erase_en_i = 1'b1;
      tick();
      bus.ld_erase_en_i = 1'b0;
      for (int i = 0; i < 6; i++) expect_wr(AWID'(i), 32'h0);
      repeat (7) tick();
      check("pre_reset_writes", 32'(sb_q.size()), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rom_we", 32'(bus.rom_we_o), 32'd0);
      check("mid_rst_rom_addr", 32'(bus.rom_addr_o), 32'd0);
      check("mid_rst_rom_wdata", bus.rom_wdata_o, 32'd0);
      check("mid_rst_hold", 32'(bus.hold_core_o), 32'd0);
      check("mid_rst_done", 32'(bus.dl_done_o), 32'd0);
      check("mid_rst_idle", 32'(bus.core_ready_o), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      bus.core_we_i    = 1'b1;
      bus.core_addr_i  = 32'h3C;
      bus.core_wdata_i = 32'hCAFEF00D;
      expect_wr(4'd15, 32'hCAFEF00D);
      tick();
      bus.core_we_i = 1'b0;
      check("post_rst_core_we", 32'(bus.rom_we_o), 32'd1);
      check("post_rst_hold", 32'(bus.hold_core_o), 32'd0);
      tick();
      check("post_rst_single_we", 32'(bus.rom_we_o), 32'd0);
      check("sb_drained_final", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rom_dl_ctrl.md
# rom_dl_ctrl

Sequences the instruction ROM write port between the UART program loader and the core data bus. On a loader erase request it holds the core, clears the whole ROM word by word, and forwards loader word writes. After an idle timeout it releases the core. It sits between the UART loader, the core/bus write path, and the ROM write port in the top level.

## Interface
- `ROM_DEPTH`, 4096: ROM size in 32-bit words; must be a power of two.
- `AW`, 12: word-address width, equal to log2(`ROM_DEPTH`).
- `IDLE_TIMEOUT`, 5000000: loader-idle cycles before download is declared done (100 ms at 50 MHz).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ld_erase_en_i` in 1: loader erase request, one-cycle pulse.
- `ld_wr_en_i` in 1: loader word write, one-cycle pulse.
- `ld_wr_addr_i` in 32: loader byte address.
- `ld_wr_data_i` in 32: loader write data.
- `core_we_i` in 1: core ROM write request.
- `core_addr_i` in 32: core byte address.
- `core_wdata_i` in 32: core write data.
- `core_ready_o` out 1: core write accepted this cycle; combinational, equals (state==IDLE).
- `rom_we_o` out 1: registered ROM write enable.
- `rom_addr_o` out AW: registered ROM word address.
- `rom_wdata_o` out 32: registered ROM write data.
- `hold_core_o` out 1: registered; holds the core in reset while high.
- `dl_done_o` out 1: registered one-cycle pulse when a download completes.

## Operation
- States:
  - IDLE: core owns the port.
  - ERASE: ROM is being cleared.
  - LOAD: loader owns the port.
  - RELEASE: single cycle.
- Address mapping: word address = byte address[AW+1:2]. Any write with byte address ≥ `ROM_DEPTH`*4 is dropped with no ROM write. Address bits [1:0] are ignored.
- IDLE:
  - `core_we_i` with an in-range address gives a ROM write of the core address/data.
  - `ld_erase_en_i` moves to ERASE with erase_ptr=0.
  - `ld_wr_en_i` in IDLE is ignored.
  - If erase and a core write occur in the same cycle, the core write is performed and ERASE starts next cycle.
- ERASE:
  - Each cycle: ROM write with addr=erase_ptr, data=0, then erase_ptr+1.
  - After writing `ROM_DEPTH`-1, move to LOAD.
  - `ld_erase_en_i` is ignored in ERASE.
  - `ld_wr_en_i` in ERASE is captured into a one-entry pending buffer (addr, data, valid). A second loader write while pending is valid overwrites it.
- LOAD:
  - If pending is valid, it is written on the first LOAD cycle and cleared.
  - A loader write in that same cycle is written the following cycle. A second one-entry skid register is allowed; no loader write is ever lost.
  - Otherwise each `ld_wr_en_i` gives a ROM write of the loader address/data.
  - Timeout counter clears on entry to LOAD and on each accepted loader write, and increments otherwise.
  - `ld_erase_en_i` in LOAD restarts ERASE with erase_ptr=0 and the counter cleared.
  - Counter == `IDLE_TIMEOUT`-1 moves to RELEASE.
- RELEASE: `dl_done_o`=1, then IDLE.
- `hold_core_o` = 1 in ERASE, LOAD and RELEASE, and 0 in IDLE.
- Timeout counter width is ceil(log2(`IDLE_TIMEOUT`)) and it must not wrap before the compare.

## Timing
- Reset values: `rom_we_o`=0, `rom_addr_o`=0, `rom_wdata_o`=0, `hold_core_o`=0, `dl_done_o`=0. State=IDLE, pending cleared, counters 0.
- Reset mid-operation aborts an erase or load immediately and releases the core after reset.
- Write latency is 1 cycle from request (or erase step) to `rom_we_o`. `rom_we_o` is high for exactly one cycle per write.
- `rom_addr_o`/`rom_wdata_o` hold their last values when `rom_we_o`=0.
- Erase: `ld_erase_en_i` at cycle T gives erase writes on cycles T+2 .. T+1+`ROM_DEPTH`. `hold_core_o` rises at T+1.
- Download end: the last loader write at cycle T gives `dl_done_o` at T+`IDLE_TIMEOUT`+2. `hold_core_o` falls one cycle later.

## Test plan
(`ROM_DEPTH`=16, `AW`=4, `IDLE_TIMEOUT`=100.)
- Core write in IDLE: `core_we_i` addr 0x8 data 0xDEADBEEF -> next cycle `rom_we_o`=1, addr 2, data 0xDEADBEEF. `core_ready_o`=1 throughout.
- Erase sweep: `ld_erase_en_i` pulse -> 16 consecutive writes, addr 0..15 with data 0. `hold_core_o`=1. `core_we_i` during the sweep produces no write and `core_ready_o`=0.
- Loader write during erase: `ld_wr_en_i` addr 0x0 data 0x00000013 at erase step 5 -> written exactly once, right after addr 15 is cleared.
- Timeout release: three loader writes at addr 0x0/0x4/0x8, then quiet -> ROM writes at addr 0/1/2. `dl_done_o` pulses 102 cycles after the last write and `hold_core_o` falls the next cycle.
- Out of range and simultaneous: loader write to 0x40 in LOAD -> no write, but the timeout still clears. Erase and core write in the same IDLE cycle -> core write first, then the sweep.
- Reset mid-erase: `rst_n` low at erase step 7 -> all outputs 0 and state IDLE. Core writes are accepted after reset.
